// File: rtl/forth_pkg.sv
// Shared definitions for the Forth core stacks: default sizes, the stack
// operation encoding and the pointer/counter width helpers used by both
// the parameter stack and the return stack.
package forth_pkg;

  // Default data word width of the core.
  localparam int WIDTH        = 16;

  // Default spill RAM depths (entries behind the dedicated top register).
  localparam int PSTACK_DEPTH = 16;
  localparam int RSTACK_DEPTH = 16;

  // Stack operation decoded from the {push, pop} strobe pair.
  typedef enum logic [1:0] {
    OP_NONE    = 2'b00,
    OP_POP     = 2'b01,
    OP_PUSH    = 2'b10,
    OP_REPLACE = 2'b11
  } stack_op_e;

  // Spill RAM pointer width; a depth of one still needs a one-bit pointer.
  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Occupancy counter width able to hold depth+1 (RAM plus top register),
  // with one bit of headroom so the full value never sits on the MSB edge.
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1) + 1;
  endfunction

endpackage

// File: rtl/pstack_ram.sv
// Spill RAM for a stack: one synchronous write port, one asynchronous
// read port. Contents are never reset; occupancy tracking lives outside.
module pstack_ram import forth_pkg::*; #(
  parameter  int width     = WIDTH,
  parameter  int depth     = PSTACK_DEPTH,
  localparam int ptr_width = ptr_w(depth)
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [ptr_width-1:0] waddr,
  input  logic [width-1:0]     wdata,
  input  logic [ptr_width-1:0] raddr,
  output logic [width-1:0]     rdata
);

  logic [width-1:0] mem_q [depth];

  // Synchronous write of one entry when enabled.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/pstack.sv
// Parameter (data) stack. The next-on-stack value is held in a dedicated
// register that feeds the ALU and memory write data directly; older
// entries spill into a circular RAM. When the stack is full a further
// push silently overwrites the oldest entry and raises a sticky overflow.
module pstack import forth_pkg::*; #(
  parameter  int width     = WIDTH,
  parameter  int depth     = PSTACK_DEPTH,
  localparam int ptr_width = ptr_w(depth),
  localparam int cnt_width = cnt_w(depth)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 wait_state,
  input  logic                 push,
  input  logic                 pop,
  input  logic [width-1:0]     push_data,
  input  logic                 err_clear,
  output logic [width-1:0]     pstack_top,
  output logic [cnt_width-1:0] count,
  output logic                 empty,
  output logic                 full,
  output logic                 overflow,
  output logic                 underflow
);

  localparam logic [cnt_width-1:0] CNT_ZERO = cnt_width'(0);
  localparam logic [cnt_width-1:0] CNT_ONE  = cnt_width'(1);
  localparam logic [cnt_width-1:0] CNT_FULL = cnt_width'(depth + 1);
  localparam logic [ptr_width-1:0] PTR_ONE  = ptr_width'(1);
  localparam logic [width-1:0]     DATA_ZERO = width'(0);

  // Architectural state.
  logic [width-1:0]     top_q,  top_d;
  logic [ptr_width-1:0] sp_q,   sp_d;
  logic [cnt_width-1:0] count_q, count_d;
  logic                 ovf_q,  ovf_d;
  logic                 unf_q,  unf_d;

  // Spill RAM interface.
  logic                 ram_we_s;
  logic [ptr_width-1:0] ram_raddr_s;
  logic [width-1:0]     ram_rdata_s;

  // Decode helpers.
  stack_op_e op_s;
  logic      is_empty_s;
  logic      is_full_s;

  assign op_s        = stack_op_e'({push, pop});
  assign is_empty_s  = (count_q == CNT_ZERO);
  assign is_full_s   = (count_q == CNT_FULL);
  assign ram_raddr_s = sp_q - PTR_ONE;

  pstack_ram #(
    .width (width),
    .depth (depth)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we_s),
    .waddr (sp_q),
    .wdata (top_q),
    .raddr (ram_raddr_s),
    .rdata (ram_rdata_s)
  );

  // Next-state decode for the top register, spill pointer, count and flags.
  always_comb begin
    top_d    = top_q;
    sp_d     = sp_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    ram_we_s = 1'b0;

    if (!wait_state) begin
      // Clearing happens first so that a fresh error this cycle wins.
      if (err_clear) begin
        ovf_d = 1'b0;
        unf_d = 1'b0;
      end else begin
        ovf_d = ovf_q;
        unf_d = unf_q;
      end

      case (op_s)
        OP_PUSH: begin
          top_d = push_data;
          if (is_empty_s) begin
            // First entry lands only in the top register.
            count_d = CNT_ONE;
          end else begin
            // Old top spills; when full this overwrites the oldest slot.
            ram_we_s = 1'b1;
            sp_d     = sp_q + PTR_ONE;
            if (is_full_s) begin
              ovf_d = 1'b1;
            end else begin
              count_d = count_q + CNT_ONE;
            end
          end
        end

        OP_POP: begin
          if (is_empty_s) begin
            unf_d = 1'b1;
          end else if (count_q == CNT_ONE) begin
            top_d   = DATA_ZERO;
            count_d = CNT_ZERO;
          end else begin
            top_d   = ram_rdata_s;
            sp_d    = sp_q - PTR_ONE;
            count_d = count_q - CNT_ONE;
          end
        end

        OP_REPLACE: begin
          // Replace NOS in place; RAM and pointer are untouched.
          top_d = push_data;
          if (is_empty_s) begin
            count_d = CNT_ONE;
            unf_d   = 1'b1;
          end else begin
            count_d = count_q;
          end
        end

        default: begin
          top_d   = top_q;
          count_d = count_q;
        end
      endcase
    end else begin
      // Stalled: everything holds, including pending error clears.
      top_d    = top_q;
      sp_d     = sp_q;
      count_d  = count_q;
      ovf_d    = ovf_q;
      unf_d    = unf_q;
      ram_we_s = 1'b0;
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      top_q   <= DATA_ZERO;
      sp_q    <= '0;
      count_q <= CNT_ZERO;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      top_q   <= top_d;
      sp_q    <= sp_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign pstack_top = top_q;
  assign count      = count_q;
  assign empty      = is_empty_s;
  assign full       = is_full_s;
  assign overflow   = ovf_q;
  assign underflow  = unf_q;

endmodule

// File: tb/tb_pstack.sv
// Self-checking bench for pstack: directed scenarios plus a randomized run,
// all checked against a queue-based model of a bounded stack.
module tb_pstack;

  localparam int W  = 16;
  localparam int D  = 16;
  localparam int CW = 6;

  logic          clk = 1'b0;
  logic          reset;
  logic          wait_state;
  logic          push;
  logic          pop;
  logic [W-1:0]  push_data;
  logic          err_clear;
  logic [W-1:0]  pstack_top;
  logic [CW-1:0] count;
  logic          empty;
  logic          full;
  logic          overflow;
  logic          underflow;

  int errors = 0;
  int checks = 0;

  // Reference model: queue of entries, newest at the back.
  logic [W-1:0] mq [$];
  bit           m_ovf;
  bit           m_unf;

  always #5 clk = ~clk;

  pstack #(.width(W), .depth(D)) dut (
    .clk        (clk),
    .reset      (reset),
    .wait_state (wait_state),
    .push       (push),
    .pop        (pop),
    .push_data  (push_data),
    .err_clear  (err_clear),
    .pstack_top (pstack_top),
    .count      (count),
    .empty      (empty),
    .full       (full),
    .overflow   (overflow),
    .underflow  (underflow)
  );

  function automatic logic [W-1:0] m_top();
    return (mq.size() > 0) ? mq[mq.size()-1] : '0;
  endfunction

  function automatic logic [W+CW+3:0] m_state();
    return {m_top(), CW'(mq.size()), (mq.size() == 0), (mq.size() == D + 1), m_ovf, m_unf};
  endfunction

  // Apply one cycle of stimulus and advance the model; sample point is #1 after the edge.
  task automatic cycle(input bit pu, input bit po, input logic [W-1:0] d,
                       input bit ec = 1'b0, input bit ws = 1'b0);
    bit err_o;
    bit err_u;
    err_o = 1'b0;
    err_u = 1'b0;
    push = pu; pop = po; push_data = d; err_clear = ec; wait_state = ws;
    @(posedge clk);
    #1;
    if (!ws) begin
      if (pu && !po) begin
        if (mq.size() == D + 1) begin
          void'(mq.pop_front());
          err_o = 1'b1;
        end
        mq.push_back(d);
      end else if (po && !pu) begin
        if (mq.size() == 0) err_u = 1'b1;
        else void'(mq.pop_back());
      end else if (pu && po) begin
        if (mq.size() == 0) begin
          mq.push_back(d);
          err_u = 1'b1;
        end else begin
          mq[mq.size()-1] = d;
        end
      end
      if (ec) begin
        m_ovf = 1'b0;
        m_unf = 1'b0;
      end
      if (err_o) m_ovf = 1'b1;
      if (err_u) m_unf = 1'b1;
    end
    push = 1'b0; pop = 1'b0; err_clear = 1'b0; wait_state = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; wait_state = 1'b0; push = 1'b0; pop = 1'b0;
    push_data = '0; err_clear = 1'b0;
    mq.delete(); m_ovf = 1'b0; m_unf = 1'b0;
    #12;
    reset = 1'b0;
    #1;
    checks++;
    if ({pstack_top, count, empty, full, overflow, underflow} !== {16'h0000, 6'd0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_state: got top=%h cnt=%0d e=%b f=%b o=%b u=%b, expected top=0000 cnt=0 e=1 f=0 o=0 u=0",
               pstack_top, count, empty, full, overflow, underflow);
    end
  endtask

  task automatic test_basic();
    logic [W-1:0] exp_seq [3];
    exp_seq[0] = 16'h2222; exp_seq[1] = 16'h1111; exp_seq[2] = 16'h0000;
    cycle(1'b1, 1'b0, 16'h1111);
    cycle(1'b1, 1'b0, 16'h2222);
    cycle(1'b1, 1'b0, 16'h3333);
    checks++;
    if ({pstack_top, count, empty} !== {16'h3333, 6'd3, 1'b0}) begin
      errors++;
      $display("FAIL basic_push: got top=%h cnt=%0d e=%b, expected top=3333 cnt=3 e=0", pstack_top, count, empty);
    end
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b1, '0);
      checks++;
      if (pstack_top !== exp_seq[i]) begin
        errors++;
        $display("FAIL basic_pop%0d: got top=%h, expected %h", i, pstack_top, exp_seq[i]);
      end
    end
    checks++;
    if ({count, empty, underflow} !== {6'd0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL basic_final: got cnt=%0d e=%b u=%b, expected cnt=0 e=1 u=0", count, empty, underflow);
    end
  endtask

  task automatic test_overflow();
    logic [W-1:0] exp_top;
    for (int i = 1; i <= 18; i++) begin
      cycle(1'b1, 1'b0, W'(i));
      if (i == 17) begin
        checks++;
        if ({full, overflow, count} !== {1'b1, 1'b0, 6'd17}) begin
          errors++;
          $display("FAIL ovf_at_full: got f=%b o=%b cnt=%0d, expected f=1 o=0 cnt=17", full, overflow, count);
        end
      end
    end
    checks++;
    if ({overflow, count, pstack_top, full} !== {1'b1, 6'd17, 16'd18, 1'b1}) begin
      errors++;
      $display("FAIL ovf_push18: got o=%b cnt=%0d top=%0d f=%b, expected o=1 cnt=17 top=18 f=1",
               overflow, count, pstack_top, full);
    end
    for (int k = 0; k < 17; k++) begin
      cycle(1'b0, 1'b1, '0);
      exp_top = (k < 16) ? W'(17 - k) : '0;
      checks++;
      if (pstack_top !== exp_top) begin
        errors++;
        $display("FAIL ovf_pop%0d: got top=%0d, expected %0d", k, pstack_top, exp_top);
      end
    end
    checks++;
    if ({count, empty, overflow, underflow} !== {6'd0, 1'b1, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL ovf_drained: got cnt=%0d e=%b o=%b u=%b, expected cnt=0 e=1 o=1 u=0",
               count, empty, overflow, underflow);
    end
    cycle(1'b0, 1'b0, '0, 1'b1);
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL ovf_clear: got o=%b, expected 0", overflow);
    end
  endtask

  task automatic test_underflow();
    cycle(1'b0, 1'b1, '0);
    checks++;
    if ({underflow, count, pstack_top} !== {1'b1, 6'd0, 16'h0000}) begin
      errors++;
      $display("FAIL unf_pop_empty: got u=%b cnt=%0d top=%h, expected u=1 cnt=0 top=0000", underflow, count, pstack_top);
    end
    cycle(1'b0, 1'b0, '0, 1'b1);
    checks++;
    if (underflow !== 1'b0) begin
      errors++;
      $display("FAIL unf_clear: got u=%b, expected 0", underflow);
    end
    cycle(1'b0, 1'b1, '0, 1'b1);
    checks++;
    if (underflow !== 1'b1) begin
      errors++;
      $display("FAIL unf_set_wins: got u=%b, expected 1", underflow);
    end
    cycle(1'b0, 1'b0, '0, 1'b1);
  endtask

  task automatic test_replace();
    cycle(1'b1, 1'b0, 16'h1234);
    cycle(1'b1, 1'b0, 16'hAAAA);
    cycle(1'b1, 1'b1, 16'hBEEF);
    checks++;
    if ({pstack_top, count, underflow} !== {16'hBEEF, 6'd2, 1'b0}) begin
      errors++;
      $display("FAIL replace: got top=%h cnt=%0d u=%b, expected top=beef cnt=2 u=0", pstack_top, count, underflow);
    end
    cycle(1'b0, 1'b1, '0);
    checks++;
    if ({pstack_top, count} !== {16'h1234, 6'd1}) begin
      errors++;
      $display("FAIL replace_pop: got top=%h cnt=%0d, expected top=1234 cnt=1", pstack_top, count);
    end
    cycle(1'b0, 1'b1, '0);
    cycle(1'b1, 1'b1, 16'h4321);
    checks++;
    if ({pstack_top, count, underflow} !== {16'h4321, 6'd1, 1'b1}) begin
      errors++;
      $display("FAIL replace_empty: got top=%h cnt=%0d u=%b, expected top=4321 cnt=1 u=1", pstack_top, count, underflow);
    end
    cycle(1'b0, 1'b1, '0, 1'b1);
  endtask

  task automatic test_wait_reset();
    cycle(1'b1, 1'b0, 16'h7777);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 1'b0, 16'h5555, 1'b0, 1'b1);
      checks++;
      if ({pstack_top, count} !== {16'h7777, 6'd1}) begin
        errors++;
        $display("FAIL wait_hold%0d: got top=%h cnt=%0d, expected top=7777 cnt=1", i, pstack_top, count);
      end
    end
    cycle(1'b1, 1'b0, 16'h8888);
    push = 1'b1; push_data = 16'h9999;
    #3;
    reset = 1'b1;
    #1;
    mq.delete(); m_ovf = 1'b0; m_unf = 1'b0;
    checks++;
    if ({pstack_top, count, empty, full} !== {16'h0000, 6'd0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL async_reset: got top=%h cnt=%0d e=%b f=%b, expected top=0000 cnt=0 e=1 f=0",
               pstack_top, count, empty, full);
    end
    @(posedge clk);
    #1;
    push = 1'b0;
    reset = 1'b0;
    #1;
    checks++;
    if ({pstack_top, count} !== {16'h0000, 6'd0}) begin
      errors++;
      $display("FAIL reset_discard: got top=%h cnt=%0d, expected top=0000 cnt=0", pstack_top, count);
    end
  endtask

  task automatic test_random();
    int bias;
    bit pu, po, ec, ws;
    for (int n = 0; n < 800; n++) begin
      bias = ((n / 100) % 2 == 0) ? 75 : 25;
      pu = ($urandom_range(0, 99) < bias);
      po = ($urandom_range(0, 99) >= bias);
      ec = ($urandom_range(0, 99) < 5);
      ws = ($urandom_range(0, 99) < 10);
      cycle(pu, po, W'($urandom), ec, ws);
      checks++;
      if ({pstack_top, count, empty, full, overflow, underflow} !== m_state()) begin
        errors++;
        $display("FAIL random_%0d: got {top,cnt,e,f,o,u}=%h, expected %h",
                 n, {pstack_top, count, empty, full, overflow, underflow}, m_state());
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_underflow();
    test_replace();
    test_wait_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pstack.md
Name: pstack

Overview:
- Parameter (data) stack that feeds the TOS datapath.
- Holds next-on-stack (NOS) in a dedicated register, `pstack_top`, with a circular spill RAM behind it.
- `pstack_top` drives the ALU second operand and the data-memory write data.
- Push/pop strobes come from the instruction decoder. `wait_state` freezes the stack in step with the TOS register.

Parameters:
- width, 16, data word width
- depth, 16, spill RAM entries; power of two, ≥2; total capacity = depth+1
- ptr_width, $clog2(depth), spill pointer width (derived, not overridden)
- cnt_width, $clog2(depth+1)+1, occupancy counter width (derived)

Ports:
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- wait_state  in  1  stall; when high no state changes
- push  in  1  push push_data onto stack this cycle
- pop  in  1  pop one entry this cycle
- push_data  in  width  value pushed (old TOS from the TOS stage)
- err_clear  in  1  synchronous clear of sticky error flags
- pstack_top  out  width  current NOS, registered
- count  out  cnt_width  number of valid entries, 0..depth+1
- empty  out  1  count==0
- full  out  1  count==depth+1
- overflow  out  1  sticky: a push occurred while full
- underflow  out  1  sticky: a pop occurred while empty

Behaviour:
- Reset (async): top_r=0, sp=0, count=0, overflow=0, underflow=0. RAM contents are not reset. Outputs: pstack_top=0, count=0, empty=1, full=0.
- State: top_r (NOS), spill RAM[depth], sp = next free RAM slot, count.
  - pstack_top = top_r.
  - empty and full decode combinationally from count.
- All updates occur on posedge clk only when wait_state=0. With wait_state=1, every register and the RAM hold, including err_clear effects.
- Latency: an op sampled at edge N is visible on pstack_top/count after edge N.
- The following cases apply when wait_state=0, evaluated against pre-edge count.
- push only:
  - RAM[sp]<=top_r; top_r<=push_data; sp<=sp+1 (mod depth).
  - If count==0: no RAM write, sp unchanged, count<=1.
  - Else if count<depth+1: count<=count+1.
  - If full: the oldest entry is overwritten (circular), count holds at depth+1, overflow<=1.
- pop only:
  - count≥2: top_r<=RAM[sp-1]; sp<=sp-1; count<=count-1.
  - count==1: top_r<=0; count<=0; sp unchanged.
  - count==0: no state change except underflow<=1; top_r holds.
- push and pop together (replace NOS):
  - top_r<=push_data; sp and RAM unchanged.
  - If count==0: count<=1 and underflow<=1. Otherwise count unchanged.
- Neither: hold.
- err_clear:
  - Clears overflow and underflow.
  - If a new error occurs in the same cycle, setting wins.
- RAM:
  - Synchronous write, asynchronous read of address sp-1.
  - A read and a write never target the same slot in one cycle.
- sp arithmetic is unsigned ptr_width and wraps naturally.
- count never exceeds depth+1 and never goes below 0.
- Reset asserted mid-operation: async clear takes priority immediately, and the in-flight op is discarded.

Decomposition:
- Shared package, forth_pkg:
  - default width constant
  - default pstack/rstack depth constants
  - cnt/ptr width helper functions
- One sub-module, pstack_ram:
  - depth×width, one write port (clk, we, waddr, wdata), one async read port (raddr, rdata).
  - Reused later by the return stack.

Test Plan:
- Reset, then push 0x1111, 0x2222, 0x3333 over three cycles -> pstack_top=0x3333, count=3, empty=0.
- Then pop three times -> pstack_top sequence 0x2222, 0x1111, 0x0000; final count=0, empty=1, underflow=0.
- Push 18 values 1..18 with depth=16:
  - After 17 pushes: full=1, overflow=0.
  - After the 18th: overflow=1, count=17, pstack_top=18.
  - Then 17 pops return 17..2 and finally 0; value 1 is lost.
- Pop on empty -> underflow=1, count=0, pstack_top unchanged.
  - err_clear for one cycle -> underflow=0.
  - err_clear concurrent with another empty pop -> underflow stays 1.
- count=2 with NOS=0xAAAA; push+pop with push_data=0xBEEF -> pstack_top=0xBEEF, count=2; then pop -> previous lower entry returned.
- Hold wait_state=1 while driving push=1 with 0x5555 for 3 cycles -> no change to pstack_top/count.
  - Assert reset asynchronously mid-cycle during a push -> outputs go to reset values before the next edge.
